twiddle_rom_seq: RTL and testbench
==================================

# twiddle_rom_seq

Parametrised twiddle-factor sequencer for the pipelined FFT datapath. It holds a table of complex twiddles in the project's small-float (sfp) format and emits one group of LANES twiddles per enabled cycle, starting group 0 after START. It drives the butterfly stage's twiddle multiplier inputs. Compared with the fixed 4-lane/8-group generator, it adds a valid/last handshake, an EN stall input, optional looping and optional inverse-FFT conjugation.

## Interface
Parameters:
- NB, 9: bits per real or imaginary word (sfp: sign at MSB, sign-magnitude).
- LANES, 4: twiddles per output group.
- GROUPS, 8: groups per sweep; table depth is LANES*GROUPS.
- LOOP, 0: 0 = one-shot sweep; 1 = wrap to group 0 and continue.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- START  in  1  synchronous sweep start/restart.
- EN  in  1  advance enable (downstream ready).
- INV  in  1  inverse mode select; present only with TWROM_CONJ_EN.
- OR  out  NB*LANES  real parts, lane 0 at LSBs.
- OI  out  NB*LANES  imaginary parts, lane 0 at LSBs.
- OVALID  out  1  OR/OI hold a valid group.
- OLAST  out  1  current group is GROUPS-1.
- OIDX  out  max(1,$clog2(GROUPS))  index of the group on OR/OI.

## Operation
- States: IDLE and RUN. Internal counter cnt has the same width as OIDX.
- Reset (asynchronous): state=IDLE, cnt=0, OR=0, OI=0, OVALID=0, OLAST=0, OIDX=0.
- IDLE:
  - START=1 → cnt=0, state=RUN.
  - Outputs hold their last values. OVALID=0.
- RUN, START=0, EN=1:
  - Register group cnt: lane j of OR/OI = table entry cnt*LANES+j.
  - OIDX=cnt, OVALID=1, OLAST=(cnt==GROUPS-1).
  - If cnt==GROUPS-1: LOOP=1 → cnt=0, stay in RUN; LOOP=0 → state=IDLE.
  - Otherwise cnt=cnt+1.
- RUN, EN=0: all outputs and cnt hold, including OVALID and OLAST (stall).
- START=1 in RUN: restart. cnt=0, state RUN, outputs and OVALID hold for that cycle. START has priority over EN.
- IDLE entered after a one-shot sweep: OVALID drops to 0 on the next edge; OLAST holds.
- GROUPS=1: every emitted group is also last.
- Table contents are W_N^k constants in sfp, indexed g*LANES+j. Defaults give the 32-entry table for the 4×8 case. Zero is encoded as all-zero bits.

## Timing
- START sampled at edge k → group 0 registered at edge k+1 if EN=1 there.
- Sustained throughput is one group per cycle with EN=1. A full sweep takes GROUPS enabled cycles after START.
- Output latency from cnt to OR/OI is one registered stage; there is no combinational path from inputs to outputs.
- Reset asserted mid-sweep clears everything immediately. After release, the block waits for START.

## Configuration
- TWROM_CONJ_EN defined:
  - INV port exists, sampled on the same edge that registers OR/OI.
  - INV=1 → each OI word has its sign bit inverted, except all-zero words, which stay 0. OR is unaffected.
- Undefined: no INV port, OI is always the table value (forward FFT only).

## Structure
- Shared include/package: NB default (the existing sfp width macro), sfp sign-bit position, and the default twiddle table as a flat constant array for LANES=4, GROUPS=8.
- Sub-module twiddle_lut: combinational, maps index → {real, imag} word from the package table.
- twiddle_rom_seq instantiates LANES copies of twiddle_lut, or one wide lookup, plus the FSM/counter/output registers.

## Test plan
- Reset with defaults, then START, EN=1 → first group OR={4{9'h080}}, OI=0, OIDX=0, OVALID=1.
- Continue EN=1 → group 4: lane0 OR=9'h177, lane1 OR=9'h000 and OI=9'h180. Group 7 has OLAST=1; then OVALID=0 with LOOP=0.
- LOOP=1, 20 enabled cycles → OIDX sequence 0..7,0..7,0..3. OLAST pulses at indices 7 only.
- EN toggled 1,0,0,1 mid-sweep → OR/OI/OIDX frozen during the low cycles, no group skipped.
- START at OIDX=5 with EN=1 → next cycle holds group 5, following cycle OIDX=0.
- TWROM_CONJ_EN with INV=1 → group 4 lane1 OI=9'h080, group 0 OI stays 0.
- Reset asserted at OIDX=3 → all outputs 0 immediately, no output until a new START.

Source files
------------

// File: rtl/twiddle_rom_seq_pkg.sv
// rtl/twiddle_rom_seq_pkg.sv - sfp word format, FSM states and default 4x8 twiddle table
package twiddle_rom_seq_pkg;

  // sfp word: sign at MSB, then 4-bit exponent (bias 8), then 4-bit mantissa; zero is all-zero bits
  localparam int SFP_NB       = 9;
  localparam int SFP_SIGN_BIT = SFP_NB - 1;

  // Default table geometry: LANES=4, GROUPS=8
  localparam int TW_DEPTH = 32;
  localparam int TW_IDXW  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } twrom_state_e;

  // Entry g*4+j = {real, imag} of W_32^(g*(3-j)); the highest lane always carries W^0
  localparam logic [2*SFP_NB-1:0] TW_TABLE [TW_DEPTH] = '{
    {9'h080, 9'h000}, {9'h080, 9'h000}, {9'h080, 9'h000}, {9'h080, 9'h000},
    {9'h07B, 9'h172}, {9'h07E, 9'h168}, {9'h07F, 9'h159}, {9'h080, 9'h000},
    {9'h068, 9'h17E}, {9'h077, 9'h177}, {9'h07E, 9'h168}, {9'h080, 9'h000},
    {9'h159, 9'h17F}, {9'h068, 9'h17E}, {9'h07B, 9'h172}, {9'h080, 9'h000},
    {9'h177, 9'h177}, {9'h000, 9'h180}, {9'h077, 9'h177}, {9'h080, 9'h000},
    {9'h17F, 9'h159}, {9'h168, 9'h17E}, {9'h072, 9'h17B}, {9'h080, 9'h000},
    {9'h17E, 9'h068}, {9'h177, 9'h177}, {9'h068, 9'h17E}, {9'h080, 9'h000},
    {9'h172, 9'h07B}, {9'h17E, 9'h168}, {9'h059, 9'h17F}, {9'h080, 9'h000}
  };

endpackage

// File: rtl/twiddle_rom_seq_lut.sv
// rtl/twiddle_rom_seq_lut.sv - twiddle_lut: combinational index to {real, imag} sfp word lookup
module twiddle_lut
  import twiddle_rom_seq_pkg::*;
#(
  parameter int NB   = SFP_NB,
  parameter int IDXW = TW_IDXW
) (
  input  logic [IDXW-1:0] idx_i,
  output logic [NB-1:0]   re_o,
  output logic [NB-1:0]   im_o
);

  logic [TW_IDXW-1:0]  tidx;
  logic [2*SFP_NB-1:0] entry;
  logic [SFP_NB-1:0]   re_w;
  logic [SFP_NB-1:0]   im_w;

  if (IDXW >= TW_IDXW) begin : g_idx_trunc
    assign tidx = idx_i[TW_IDXW-1:0];
  end else begin : g_idx_ext
    assign tidx = {{(TW_IDXW-IDXW){1'b0}}, idx_i};
  end

  // Table read; indices beyond the stored table read as zero
  always_comb begin
    entry = '0;
    if (int'(idx_i) < TW_DEPTH) begin
      entry = TW_TABLE[tidx];
    end
  end

  assign re_w = entry[2*SFP_NB-1:SFP_NB];
  assign im_w = entry[SFP_NB-1:0];

  // Other word widths keep the sign at MSB and the exponent on top; the mantissa is extended or cut
  if (NB == SFP_NB) begin : g_nb_same
    assign re_o = re_w;
    assign im_o = im_w;
  end else if (NB > SFP_NB) begin : g_nb_wide
    assign re_o = {re_w, {(NB-SFP_NB){1'b0}}};
    assign im_o = {im_w, {(NB-SFP_NB){1'b0}}};
  end else begin : g_nb_narrow
    assign re_o = re_w[SFP_NB-1 -: NB];
    assign im_o = im_w[SFP_NB-1 -: NB];
  end

endmodule

// File: rtl/twiddle_rom_seq.sv
// rtl/twiddle_rom_seq.sv - twiddle group sequencer with EN stall, optional loop; TWROM_CONJ_EN adds INV conjugation
module twiddle_rom_seq
  import twiddle_rom_seq_pkg::*;
#(
  parameter int NB     = SFP_NB,
  parameter int LANES  = 4,
  parameter int GROUPS = 8,
  parameter int LOOP   = 0,
  localparam int CW    = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int IDXW  = (LANES * GROUPS > 1) ? $clog2(LANES * GROUPS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                EN,
`ifdef TWROM_CONJ_EN
  input  logic                INV,
`endif
  output logic [NB*LANES-1:0] OR,
  output logic [NB*LANES-1:0] OI,
  output logic                OVALID,
  output logic                OLAST,
  output logic [CW-1:0]       OIDX
);

  localparam logic [CW-1:0] LAST_CNT = CW'(GROUPS - 1);

  twrom_state_e        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       oidx_q, oidx_d;
  logic [NB*LANES-1:0] or_q, or_d;
  logic [NB*LANES-1:0] oi_q, oi_d;
  logic                ovalid_q, ovalid_d;
  logic                olast_q, olast_d;
  logic [NB*LANES-1:0] grp_re;
  logic [NB*LANES-1:0] grp_im;

`ifdef TWROM_CONJ_EN
  localparam logic [NB-1:0] SIGN_MASK = {1'b1, {(NB-1){1'b0}}};
`endif

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [IDXW-1:0] idx;
    logic [NB-1:0]   re_w;
    logic [NB-1:0]   im_w;

    assign idx = IDXW'(cnt_q) * IDXW'(LANES) + IDXW'(j);

    twiddle_lut #(
      .NB   (NB),
      .IDXW (IDXW)
    ) u_lut (
      .idx_i (idx),
      .re_o  (re_w),
      .im_o  (im_w)
    );

    assign grp_re[j*NB +: NB] = re_w;
`ifdef TWROM_CONJ_EN
    // Inverse mode negates the imaginary part; zero stays zero rather than becoming negative zero
    assign grp_im[j*NB +: NB] = (INV && (im_w != '0)) ? (im_w ^ SIGN_MASK) : im_w;
`else
    assign grp_im[j*NB +: NB] = im_w;
`endif
  end

  // Next state: START restarts without touching outputs, EN loads the addressed group, otherwise hold
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    oidx_d   = oidx_q;
    or_d     = or_q;
    oi_d     = oi_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    case (state_q)
      ST_IDLE: begin
        ovalid_d = 1'b0;
        if (START) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (START) begin
          cnt_d = '0;
        end else if (EN) begin
          or_d     = grp_re;
          oi_d     = grp_im;
          oidx_d   = cnt_q;
          ovalid_d = 1'b1;
          olast_d  = (cnt_q == LAST_CNT);
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (LOOP == 0) begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and output registers; reset clears everything at once
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      oidx_q   <= '0;
      or_q     <= '0;
      oi_q     <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oidx_q   <= oidx_d;
      or_q     <= or_d;
      oi_q     <= oi_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

  assign OR     = or_q;
  assign OI     = oi_q;
  assign OVALID = ovalid_q;
  assign OLAST  = olast_q;
  assign OIDX   = oidx_q;

endmodule

// File: tb/tb_twiddle_rom_seq.sv
// tb/tb_twiddle_rom_seq.sv - bench for twiddle_rom_seq (one-shot and looping instances; TWROM_CONJ_EN aware)
module tb_twiddle_rom_seq;

  logic CLK = 1'b0;
  logic RST;
  logic START;
  logic EN;
  logic INV_s;

  logic [35:0] or0, oi0, or1, oi1;
  logic        v0, l0, v1, l1;
  logic [2:0]  x0, x1;

  always #5 CLK = ~CLK;

  twiddle_rom_seq #(.NB(9), .LANES(4), .GROUPS(8), .LOOP(0)) dut0 (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .EN     (EN),
`ifdef TWROM_CONJ_EN
    .INV    (INV_s),
`endif
    .OR     (or0),
    .OI     (oi0),
    .OVALID (v0),
    .OLAST  (l0),
    .OIDX   (x0)
  );

  twiddle_rom_seq #(.NB(9), .LANES(4), .GROUPS(8), .LOOP(1)) dut1 (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .EN     (EN),
`ifdef TWROM_CONJ_EN
    .INV    (INV_s),
`endif
    .OR     (or1),
    .OI     (oi1),
    .OVALID (v1),
    .OLAST  (l1),
    .OIDX   (x1)
  );

  logic [8:0]  tw_re [32];
  logic [8:0]  tw_im [32];
  int          m_run [2];
  int          m_cnt [2];
  logic [35:0] e_or [2];
  logic [35:0] e_oi [2];
  logic        e_v [2];
  logic        e_l [2];
  logic [2:0]  e_x [2];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [8:0] sfp_enc(input real x);
    real  mag, s;
    int   e, m;
    logic sgn;
    sgn = (x < 0.0);
    mag = sgn ? -x : x;
    if (mag < 1.0e-6) return 9'h000;
    e = 8;
    s = 1.0;
    while (mag < s && e > 0) begin
      s = s / 2.0;
      e--;
    end
    m = int'($floor((mag / s - 1.0) * 16.0 + 0.5));
    if (m >= 16) begin
      m = 0;
      e++;
    end
    return {sgn, 4'(e), 4'(m)};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0;
      m_cnt[d] = 0;
      e_or[d]  = '0;
      e_oi[d]  = '0;
      e_v[d]   = 1'b0;
      e_l[d]   = 1'b0;
      e_x[d]   = '0;
    end
  endtask

  task automatic model_update(input int d, input logic st, input logic en, input logic inv);
    logic [8:0] im;
    if (m_run[d] == 0) begin
      e_v[d] = 1'b0;
      if (st) begin
        m_run[d] = 1;
        m_cnt[d] = 0;
      end
    end else if (st) begin
      m_cnt[d] = 0;
    end else if (en) begin
      for (int j = 0; j < 4; j++) begin
        e_or[d][j*9 +: 9] = tw_re[m_cnt[d]*4 + j];
        im = tw_im[m_cnt[d]*4 + j];
        if (inv && im != 9'h000) im[8] = ~im[8];
        e_oi[d][j*9 +: 9] = im;
      end
      e_v[d] = 1'b1;
      e_l[d] = (m_cnt[d] == 7);
      e_x[d] = 3'(m_cnt[d]);
      if (m_cnt[d] == 7) begin
        m_cnt[d] = 0;
        if (d == 0) m_run[d] = 0;
      end else begin
        m_cnt[d]++;
      end
    end
  endtask

  task automatic check_all();
    chk("d0.OR", or0, e_or[0]);
    chk("d0.OI", oi0, e_oi[0]);
    chk("d0.OVALID", 36'(v0), 36'(e_v[0]));
    chk("d0.OLAST", 36'(l0), 36'(e_l[0]));
    chk("d0.OIDX", 36'(x0), 36'(e_x[0]));
    chk("d1.OR", or1, e_or[1]);
    chk("d1.OI", oi1, e_oi[1]);
    chk("d1.OVALID", 36'(v1), 36'(e_v[1]));
    chk("d1.OLAST", 36'(l1), 36'(e_l[1]));
    chk("d1.OIDX", 36'(x1), 36'(e_x[1]));
  endtask

  task automatic step(input logic st, input logic en, input logic inv);
    START = st;
    EN    = en;
    INV_s = inv;
    @(posedge CLK);
    model_update(0, st, en, inv);
    model_update(1, st, en, inv);
    #1;
    check_all();
  endtask

  initial begin
    int   k;
    real  a;
    logic inv_r;

    RST   = 1'b0;
    START = 1'b0;
    EN    = 1'b0;
    INV_s = 1'b0;
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 4; j++) begin
        k = (g * (3 - j)) % 32;
        a = 2.0 * 3.14159265358979 * real'(k) / 32.0;
        tw_re[g*4 + j] = sfp_enc($cos(a));
        tw_im[g*4 + j] = sfp_enc(-$sin(a));
      end
    end
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    @(negedge CLK);
    RST = 1'b1;

    // Idle without START: nothing is emitted
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // One-shot sweep from START
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("g0.OR", or0, {4{9'h080}});
    chk("g0.OI", oi0, 36'h0);
    chk("g0.OIDX", 36'(x0), 36'h0);
    chk("g0.OVALID", 36'(v0), 36'h1);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    chk("g4.lane0.OR", 36'(or0[8:0]), 36'h177);
    chk("g4.lane1.OR", 36'(or0[17:9]), 36'h000);
    chk("g4.lane1.OI", 36'(oi0[17:9]), 36'h180);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk("g7.OLAST", 36'(l0), 36'h1);
    chk("g7.OIDX", 36'(x0), 36'h7);
    step(1'b0, 1'b1, 1'b0);
    chk("end.OVALID", 36'(v0), 36'h0);
    chk("end.OLAST_hold", 36'(l0), 36'h1);

    // Looping instance: 20 enabled cycles
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("loop.OIDX[%0d]", i), 36'(x1), 36'(i % 8));
      chk($sformatf("loop.OLAST[%0d]", i), 36'(l1), 36'((i % 8) == 7));
    end

    // EN stall 1,0,0,1: outputs freeze, no group skipped
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("stall1.OIDX", 36'(x0), 36'h2);
    step(1'b0, 1'b0, 1'b0);
    chk("stall2.OIDX", 36'(x0), 36'h2);
    chk("stall2.OVALID", 36'(v0), 36'h1);
    step(1'b0, 1'b1, 1'b0);
    chk("unstall.OIDX", 36'(x0), 36'h3);

    // START at OIDX=5 with EN=1
    repeat (2) step(1'b0, 1'b1, 1'b0);
    chk("pre_restart.OIDX", 36'(x0), 36'h5);
    step(1'b1, 1'b1, 1'b0);
    chk("restart_hold.OIDX", 36'(x0), 36'h5);
    chk("restart_hold.OVALID", 36'(v0), 36'h1);
    step(1'b0, 1'b1, 1'b0);
    chk("restart.OIDX", 36'(x0), 36'h0);

`ifdef TWROM_CONJ_EN
    // Inverse mode: imaginary signs flip, zeros stay zero
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("inv.g0.OI", oi0, 36'h0);
    repeat (4) step(1'b0, 1'b1, 1'b1);
    chk("inv.g4.lane1.OI", 36'(oi0[17:9]), 36'h080);
`endif

    // Randomized START/EN/INV traffic
    for (int i = 0; i < 400; i++) begin
      inv_r = 1'b0;
`ifdef TWROM_CONJ_EN
      inv_r = 1'($urandom % 2);
`endif
      step(($urandom % 16) == 0, ($urandom % 4) != 0, inv_r);
    end

    // Reset asserted mid-sweep at OIDX=3
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    chk("pre_reset.OIDX", 36'(x0), 36'h3);
    RST = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset.OR", or0, 36'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk("post_reset.OVALID", 36'(v0), 36'h0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("post_reset_start.OVALID", 36'(v0), 36'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
